serial_add_unit: RTL and testbench



---
 rtl/serial_add_if.sv | 26 ++
 rtl/serial_add_unit.sv | 114 +++++++++++
 tb/tb_serial_add_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/serial_add_if.sv
// Handshake and operand/result bundle for serial_add_unit.
// The sub field exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_if #(
    parameter int W = 8
);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

`ifdef SERIAL_ADD_SUB_EN
    modport master (output start, a, b, cin, sub, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`endif
endinterface

// File: rtl/serial_add_unit.sv
// serial_add_unit: W-bit bit-serial adder (LSB first), one full-adder cell
// plus a carry flop. Start/busy/done handshake; results held until the
// next operation completes.
// Optional macro SERIAL_ADD_SUB_EN adds a sub input giving A-B mod 2^W.
module serial_add_unit #(
    parameter int W     = 8,
    parameter int CNT_W = $clog2(W) + 1
) (
    input  logic         clk,
    input  logic         rst,
    serial_add_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state_q, state_d;
    logic [W-1:0] sha_q, sha_d;
    logic [W-1:0] shb_q, shb_d;
    logic [W-1:0] res_q, res_d;
    logic         carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0] sum_q, sum_d;
    logic         cout_q, cout_d;
    logic         ovf_q, ovf_d;

    logic         fa_s, fa_c;
    logic [W-1:0] b_cap;
    logic         c_cap;

    // Full-adder cell on the current LSBs, plus operand conditioning at capture
    always_comb begin
        fa_s = sha_q[0] ^ shb_q[0] ^ carry_q;
        fa_c = (sha_q[0] & shb_q[0]) | (sha_q[0] & carry_q) | (shb_q[0] & carry_q);
`ifdef SERIAL_ADD_SUB_EN
        // Subtract as A + ~B + 1; cin is ignored in that mode
        b_cap = bus.sub ? ~bus.b : bus.b;
        c_cap = bus.sub ? 1'b1 : bus.cin;
`else
        b_cap = bus.b;
        c_cap = bus.cin;
`endif
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        sha_d   = sha_q;
        shb_d   = shb_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sha_d   = bus.a;
                    shb_d   = b_cap;
                    carry_d = c_cap;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d   = {fa_s, res_q[W-1:1]};
                sha_d   = sha_q >> 1;
                shb_d   = shb_q >> 1;
                carry_d = fa_c;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(W - 1)) begin
                    // Last bit: carry_q is the carry into the MSB, fa_c the carry out
                    sum_d   = {fa_s, res_q[W-1:1]};
                    cout_d  = fa_c;
                    ovf_d   = carry_q ^ fa_c;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sha_q   <= '0;
            shb_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_add_unit.sv
// Directed bench for serial_add_unit (W=8). Inputs driven and outputs
// sampled on the falling edge.
module tb_serial_add_unit;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_asserts = 0;
    int   n_fails   = 0;

    serial_add_if #(.W(W)) bus ();

    serial_add_unit #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic ci, input logic sb);
        bus.a   = a;
        bus.b   = b;
        bus.cin = ci;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub = sb;
`else
        if (sb) $display("note: sub requested in an add-only build");
`endif
    endtask

    // Pulse start for one edge; returns at the falling edge after acceptance.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic sb);
        @(negedge clk);
        set_ops(a, b, ci, sb);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        set_ops('0, '0, 1'b0, 1'b0); // operands may change freely after capture
    endtask

    // Wait for done (bounded), check W edges from acceptance to the done
    // cycle, that the old result is held meanwhile, then the new result.
    task automatic finish_op(input string tag, input logic [W-1:0] prev,
                             input logic [W-1:0] es, input logic ec, input logic eo);
        int k;
        k = 0;
        chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
        while (!bus.done && k < W + 6) begin
            if (k == 3) chk({tag, ".held"}, 32'(bus.sum), 32'(prev));
            @(negedge clk);
            k++;
        end
        chk({tag, ".lat"}, 32'(k), 32'(W));
        chk({tag, ".sum"}, 32'(bus.sum), 32'(es));
        chk({tag, ".cout"}, 32'(bus.cout), 32'(ec));
        chk({tag, ".ovf"}, 32'(bus.ovf), 32'(eo));
        chk({tag, ".busy_dn"}, 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk({tag, ".pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b1;
        set_ops(8'h00, 8'h00, 1'b0, 1'b0);

        // Reset held two cycles with start high: nothing begins
        @(negedge clk);
        @(negedge clk);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.done", 32'(bus.done), 32'd0);
        chk("rst.sum",  32'(bus.sum),  32'h00);
        chk("rst.cout", 32'(bus.cout), 32'd0);
        chk("rst.ovf",  32'(bus.ovf),  32'd0);
        bus.start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("rst.idle", 32'(bus.busy), 32'd0);

        // 0x35 + 0x4A = 0x7F
        launch(8'h35, 8'h4A, 1'b0, 1'b0);
        finish_op("add1", 8'h00, 8'h7F, 1'b0, 1'b0);

        // 0xFF + 0x01 wraps to 0x00 with carry out, no signed overflow
        launch(8'hFF, 8'h01, 1'b0, 1'b0);
        finish_op("wrap", 8'h7F, 8'h00, 1'b1, 1'b0);

        // 0x7F + 0x01 = 0x80: signed overflow, no carry
        launch(8'h7F, 8'h01, 1'b0, 1'b0);
        finish_op("ovf", 8'h00, 8'h80, 1'b0, 1'b1);

        // 0x80 + 0x80 + 1 = 0x101: carry and signed overflow together
        launch(8'h80, 8'h80, 1'b1, 1'b0);
        finish_op("negovf", 8'h80, 8'h01, 1'b1, 1'b1);

        // Carry-in only; a start pulse during RUN must be ignored
        launch(8'h00, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        set_ops(8'hAA, 8'h11, 1'b0, 1'b0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("ign.held", 32'(bus.sum), 32'h01);
        begin
            int k;
            k = 2;
            while (!bus.done && k < W + 6) begin
                @(negedge clk);
                k++;
            end
            chk("ign.lat", 32'(k), 32'(W));
        end
        chk("ign.sum",  32'(bus.sum),  32'h01);
        chk("ign.cout", 32'(bus.cout), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("ign.noq", 32'(bus.busy), 32'd0);

        // Reset during RUN: abort, no done, outputs cleared
        launch(8'h0F, 8'h0F, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort.busy", 32'(bus.busy), 32'd0);
        chk("abort.sum",  32'(bus.sum),  32'h00);
        chk("abort.cout", 32'(bus.cout), 32'd0);
        begin
            logic seen;
            seen = 1'b0;
            repeat (W + 3) begin
                @(negedge clk);
                seen = seen | bus.done;
            end
            chk("abort.nodone", 32'(seen), 32'd0);
        end

        // Normal operation after abort: 0x12 + 0x34 + 1 = 0x47
        launch(8'h12, 8'h34, 1'b1, 1'b0);
        finish_op("post", 8'h00, 8'h47, 1'b0, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
        // 0x10 - 0x20 = 0xF0 with borrow (cout=0); cin must be ignored
        launch(8'h10, 8'h20, 1'b0, 1'b1);
        finish_op("sub1", 8'h47, 8'hF0, 1'b0, 1'b0);
        // 0x80 - 0x01 = 0x7F, no borrow, signed overflow
        launch(8'h80, 8'h01, 1'b1, 1'b1);
        finish_op("sub2", 8'hF0, 8'h7F, 1'b1, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end
endmodule
